// File: rtl/linear_engine_seq.sv
// linear_engine_seq
//   Sequencer for the tiled linear (matmul) engine. A one-cycle start pulse
//   launches a walk over the output tile space in M, N, K order. Each step
//   issues an activation/weight tile read, then drives the MAC controls one
//   cycle later (fixed 1-cycle memory latency). A write strobe for the output
//   tile follows one cycle after the last k. A one-cycle done pulse is given
//   once the final output write has been issued.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   start        one-cycle request pulse (accepted only when idle)
//   mem_ready    operand memories accept a read this cycle
//   done         one-cycle completion pulse
//   busy         high from start acceptance through done
//   a_rd_en      activation read strobe,  a_rd_addr = m*K_TILES+k
//   w_rd_en      weight read strobe,      w_rd_addr = k*N_TILES+n
//   mac_valid    operand data valid at the MAC
//   mac_clear    first k of a tile (MAC loads instead of accumulating)
//   mac_last     last k of a tile
//   out_wr_en    output tile write strobe, out_wr_addr = m*N_TILES+n
module linear_engine_seq #(
   parameter int M_TILES = 4,
   parameter int N_TILES = 4,
   parameter int K_TILES = 8,
   parameter int ADDR_W  = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mem_ready,
   output logic              done,
   output logic              busy,
   output logic              a_rd_en,
   output logic [ADDR_W-1:0] a_rd_addr,
   output logic              w_rd_en,
   output logic [ADDR_W-1:0] w_rd_addr,
   output logic              mac_valid,
   output logic              mac_clear,
   output logic              mac_last,
   output logic              out_wr_en,
   output logic [ADDR_W-1:0] out_wr_addr
);

   // Counter widths; a single tile still needs a 1-bit register.
   localparam int MW = (M_TILES > 1) ? $clog2(M_TILES) : 1;
   localparam int NW = (N_TILES > 1) ? $clog2(N_TILES) : 1;
   localparam int KW = (K_TILES > 1) ? $clog2(K_TILES) : 1;

   localparam logic [MW-1:0] M_LAST = MW'(M_TILES - 1);
   localparam logic [NW-1:0] N_LAST = NW'(N_TILES - 1);
   localparam logic [KW-1:0] K_LAST = KW'(K_TILES - 1);

   localparam logic [ADDR_W-1:0] K_MUL = ADDR_W'(K_TILES);
   localparam logic [ADDR_W-1:0] N_MUL = ADDR_W'(N_TILES);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next;

   logic [MW-1:0]     r_m;
   logic [NW-1:0]     r_n;
   logic [KW-1:0]     r_k;

   logic              w_issue;
   logic              w_k_wrap;
   logic              w_n_wrap;
   logic              w_m_wrap;
   logic              w_final;
   logic [ADDR_W-1:0] w_a_addr;
   logic [ADDR_W-1:0] w_w_addr;
   logic [ADDR_W-1:0] w_o_addr;

   // MAC stage (1 cycle after issue) and write stage (2 cycles after issue)
   logic              r_mac_valid;
   logic              r_mac_clear;
   logic              r_mac_last;
   logic [ADDR_W-1:0] r_mac_oaddr;
   logic              r_out_wr_en;
   logic [ADDR_W-1:0] r_out_wr_addr;

   assign w_issue  = (r_state == S_RUN) && mem_ready;
   assign w_k_wrap = (r_k == K_LAST);
   assign w_n_wrap = (r_n == N_LAST);
   assign w_m_wrap = (r_m == M_LAST);
   assign w_final  = w_issue && w_k_wrap && w_n_wrap && w_m_wrap;

   assign w_a_addr = ADDR_W'(r_m) * K_MUL + ADDR_W'(r_k);
   assign w_w_addr = ADDR_W'(r_k) * N_MUL + ADDR_W'(r_n);
   assign w_o_addr = ADDR_W'(r_m) * N_MUL + ADDR_W'(r_n);

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (start)   w_next = S_RUN;
         S_RUN:   if (w_final) w_next = S_DRAIN;
         // No reads are issued in DRAIN, so once the MAC stage empties the
         // final output write is on the port this cycle.
         S_DRAIN: if (!r_mac_valid) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // ---------------- tile counters ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_m <= '0;
         r_n <= '0;
         r_k <= '0;
      end else if (r_state == S_IDLE && start) begin
         r_m <= '0;
         r_n <= '0;
         r_k <= '0;
      end else if (w_issue) begin
         if (w_k_wrap) begin
            r_k <= '0;
            if (w_n_wrap) begin
               r_n <= '0;
               r_m <= w_m_wrap ? '0 : r_m + 1'b1;
            end else begin
               r_n <= r_n + 1'b1;
            end
         end else begin
            r_k <= r_k + 1'b1;
         end
      end
   end

   // ---------------- read pipeline ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mac_valid   <= 1'b0;
         r_mac_clear   <= 1'b0;
         r_mac_last    <= 1'b0;
         r_mac_oaddr   <= '0;
         r_out_wr_en   <= 1'b0;
         r_out_wr_addr <= '0;
      end else begin
         r_mac_valid   <= w_issue;
         r_mac_clear   <= w_issue && (r_k == '0);
         r_mac_last    <= w_issue && w_k_wrap;
         r_mac_oaddr   <= w_issue ? w_o_addr : '0;
         r_out_wr_en   <= r_mac_valid && r_mac_last;
         r_out_wr_addr <= (r_mac_valid && r_mac_last) ? r_mac_oaddr : '0;
      end
   end

   // ---------------- outputs ----------------
   // Addresses are zeroed when no read is issued so idle ports read as 0.
   assign a_rd_en     = w_issue;
   assign w_rd_en     = w_issue;
   assign a_rd_addr   = w_issue ? w_a_addr : '0;
   assign w_rd_addr   = w_issue ? w_w_addr : '0;
   assign mac_valid   = r_mac_valid;
   assign mac_clear   = r_mac_clear;
   assign mac_last    = r_mac_last;
   assign out_wr_en   = r_out_wr_en;
   assign out_wr_addr = r_out_wr_addr;
   assign busy        = (r_state != S_IDLE);
   assign done        = (r_state == S_DONE);

endmodule

// File: doc/linear_engine_seq.md
# linear_engine_seq

Sequencer for the tiled linear (matmul) engine that sits on the engine side of the block controller's start/done handshake. A one-cycle `start` pulse from the controller is the trigger. The block then walks the output tile space in M, N, K order, issuing operand reads and MAC control, and writes each finished output tile. It returns a one-cycle `done` pulse when the last tile write has been issued. One instance serves each linear stage: QKV/out projection, FFN1 and FFN2.

## Interface
- `M_TILES`, default 4: output row tiles (≥1)
- `N_TILES`, default 4: output column tiles (≥1)
- `K_TILES`, default 8: reduction tiles per output tile (≥1)
- `ADDR_W`, default 12: tile address width; must satisfy `M_TILES*K_TILES`, `K_TILES*N_TILES`, `M_TILES*N_TILES` ≤ 2^ADDR_W
- `clk` in 1: clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle request pulse from controller
- `mem_ready` in 1: operand memories can accept a read this cycle
- `done` out 1: one-cycle completion pulse to controller
- `busy` out 1: high from start acceptance until `done`, inclusive
- `a_rd_en` out 1: activation tile read strobe
- `a_rd_addr` out ADDR_W: activation tile address, m*K_TILES+k
- `w_rd_en` out 1: weight tile read strobe, always equal to `a_rd_en`
- `w_rd_addr` out ADDR_W: weight tile address, k*N_TILES+n
- `mac_valid` out 1: operand data valid at MAC this cycle
- `mac_clear` out 1: with `mac_valid`, first k of a tile; MAC loads instead of accumulating
- `mac_last` out 1: with `mac_valid`, last k of a tile
- `out_wr_en` out 1: output tile write strobe
- `out_wr_addr` out ADDR_W: output tile address, m*N_TILES+n

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - `start`=1 → RUN; clear m, n, k counters.
  - `start` is ignored in every other state (no queuing).
- **RUN**
  - Each cycle with `mem_ready`=1: assert `a_rd_en`/`w_rd_en` with the current addresses, then advance k.
  - On k wrap, advance n; on n wrap, advance m.
  - `mem_ready`=0: no read issued, counters hold.
  - After issuing the read for (M_TILES-1, N_TILES-1, K_TILES-1) → DRAIN.
- **Read pipeline**
  - Memories have fixed 1-cycle read latency and never stall once a read is issued.
  - Issue flags (valid, clear = k==0, last = k==K_TILES-1) and the output address are delayed 1 cycle to form `mac_valid`/`mac_clear`/`mac_last`.
  - A further 1-cycle delay of `mac_last` forms `out_wr_en`, with `out_wr_addr` aligned to it.
- **DRAIN**: wait until the final `out_wr_en` has issued → DONE.
- **DONE**: `done`=1 for exactly one cycle → IDLE.
- When K_TILES=1, `mac_clear` and `mac_last` are both high on every `mac_valid`.
- All counters use `$clog2`-sized registers. Addresses are computed unsigned and zero-extended to ADDR_W.

## Timing
- **Reset**
  - `reset`=0 asynchronously forces IDLE, zeroes all counters and pipeline flags, and drives every output to 0.
  - Reset mid-operation aborts without `done`. In-flight `mac_valid`/`out_wr_en` are dropped.
- Cycle 0 is the edge that samples `start`=1.
- With `mem_ready` held high, let T = M_TILES*N_TILES*K_TILES:
  - reads are issued in cycles 1..T;
  - `mac_valid` is high in cycles 2..T+1;
  - the final `out_wr_en` is in cycle T+2;
  - `done` is in cycle T+3;
  - `busy` is high in cycles 1..T+3.
- Each stall cycle (`mem_ready`=0 in RUN) adds exactly one cycle to every later event.
- A `start` in the same cycle as `done` is ignored. A `start` in the cycle after `done` (IDLE) is accepted.
- `out_wr_en` count per run is exactly M_TILES*N_TILES. `mac_valid` count is exactly T.

## Test plan
- **Minimal run.** M=N=K=1, `start` at cycle 0 → `a_rd_en` at 1 with addr 0; `mac_valid`+`mac_clear`+`mac_last` at 2; `out_wr_en` addr 0 at 3; `done` at 4.
- **Address walk.** M=2, N=2, K=3, `mem_ready`=1 →
  - `a_rd_addr` sequence 0,1,2,0,1,2,3,4,5,3,4,5;
  - `w_rd_addr` sequence 0,2,4,1,3,5,0,2,4,1,3,5;
  - `out_wr_addr` 0,1,2,3 at cycles 5,8,11,14;
  - `done` at 15.
- **Stall.** Same config, `mem_ready`=0 for cycles 4–6 → no reads in 4–6; addresses resume unchanged; `done` at 18.
- **Start while busy.** Extra `start` pulses at cycles 3 and 15 (the `done` cycle) → ignored: still exactly 4 `out_wr_en`, one `done`.
- **Reset mid-run.** Assert `reset`=0 at cycle 7 → all outputs 0 immediately; no `done`. A new `start` after release runs a full sequence from address 0.
- **Back-to-back.** `start` in the cycle after `done` → second full run with identical timing relative to its start.
